// File: rtl/load_counter_pkg.sv
// Shared constants for the load counter and its button debouncers.
//   LOAD_W               width of the occupancy count driven to the decoder
//   DEF_DEBOUNCE_CYCLES  default number of stable synchronised samples
//   DEF_MAX_LOAD         default saturation ceiling of the count
//   db_cnt_w()           debounce counter width for a given cycle count
package load_counter_pkg;

    localparam int LOAD_W              = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_MAX_LOAD        = 7;

    // The counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
    function automatic int db_cnt_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/load_counter_btn_debounce.sv
// Raw push-button conditioner: two-flop synchroniser, debounce counter and
// rising-edge press pulse.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   raw    raw button level, asynchronous to clk
//   pulse  one-cycle pulse per accepted 0->1 transition of the debounced level
module btn_debounce
    import load_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = db_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic             db;
    logic             db_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            db_q  <= db;
            // Any sample agreeing with the accepted level restarts the run.
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pulse = db & ~db_q;

endmodule

// File: rtl/load_counter.sv
// Saturating occupancy counter driven by debounced increment/decrement
// buttons; feeds the 3-bit load code to the 7-segment load decoder.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   inc_btn  raw increment button (asynchronous, active high)
//   dec_btn  raw decrement button (asynchronous, active high)
//   clr      synchronous clear of the count
//   L2..L0   count bits, MSB..LSB, straight from the count register
//   full     count == MAX_LOAD
//   empty    count == 0
//   ovf_err  one-cycle pulse: increment rejected at full
//   udf_err  one-cycle pulse: decrement rejected at empty
module load_counter
    import load_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MAX_LOAD        = DEF_MAX_LOAD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_btn,
    input  logic dec_btn,
    input  logic clr,
    output logic L2,
    output logic L1,
    output logic L0,
    output logic full,
    output logic empty,
    output logic ovf_err,
    output logic udf_err
);

    localparam logic [LOAD_W-1:0] MAX_CNT = LOAD_W'(MAX_LOAD);

    logic              inc_p;
    logic              dec_p;
    logic [LOAD_W-1:0] count;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (inc_btn),
        .pulse (inc_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (dec_btn),
        .pulse (dec_p)
    );

    // Priority: clr, then coincident presses cancel, then inc, then dec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (inc_p && !dec_p) begin
                if (count < MAX_CNT) begin
                    count <= count + 1'b1;
                end else begin
                    ovf_err <= 1'b1;
                end
            end else if (dec_p && !inc_p) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else begin
                    udf_err <= 1'b1;
                end
            end
        end
    end

    assign L2    = count[2];
    assign L1    = count[1];
    assign L0    = count[0];
    assign full  = (count == MAX_CNT);
    assign empty = (count == '0);

endmodule

// File: tb/tb_load_counter.sv
module tb_load_counter;

    localparam int N    = 4;
    localparam int MAXL = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inc_btn = 1'b0;
    logic dec_btn = 1'b0;
    logic clr = 1'b0;
    logic L2, L1, L0, full, empty, ovf_err, udf_err;

    load_counter #(.DEBOUNCE_CYCLES(N), .MAX_LOAD(MAXL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_btn (inc_btn),
        .dec_btn (dec_btn),
        .clr     (clr),
        .L2      (L2),
        .L1      (L1),
        .L0      (L0),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit ovf;
        bit udf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: a button level is accepted once the last N
    // synchronised samples (raw delayed by two edges) all disagree with it;
    // the press takes effect on the edge after acceptance.
    bit hq_inc[$];
    bit hq_dec[$];
    bit mdb[2];
    bit mrose[2];
    int mcount;

    task automatic model_reset();
        hq_inc.delete();
        hq_dec.delete();
        for (int k = 0; k < N + 2; k++) begin
            hq_inc.push_back(1'b0);
            hq_dec.push_back(1'b0);
        end
        mdb[0] = 1'b0; mdb[1] = 1'b0;
        mrose[0] = 1'b0; mrose[1] = 1'b0;
        mcount = 0;
    endtask

    task automatic btn_step(input int b, input bit raw, output bit press);
        bit q[$];
        bit all_diff;
        q = (b == 0) ? hq_inc : hq_dec;
        press = mrose[b];
        q.push_back(raw);
        if (q.size() > N + 2) void'(q.pop_front());
        all_diff = 1'b1;
        for (int k = 0; k < N; k++)
            if (q[q.size() - 3 - k] == mdb[b]) all_diff = 1'b0;
        mrose[b] = 1'b0;
        if (all_diff) begin
            mdb[b]   = ~mdb[b];
            mrose[b] = mdb[b];
        end
        if (b == 0) hq_inc = q; else hq_dec = q;
    endtask

    task automatic model_edge(input bit i, input bit d, input bit c, output exp_t e);
        bit ip, dp;
        btn_step(0, i, ip);
        btn_step(1, d, dp);
        e.ovf = 1'b0;
        e.udf = 1'b0;
        if (c) mcount = 0;
        else if (ip && dp) mcount = mcount;
        else if (ip) begin
            if (mcount < MAXL) mcount++; else e.ovf = 1'b1;
        end else if (dp) begin
            if (mcount > 0) mcount--; else e.udf = 1'b1;
        end
        e.cnt = mcount;
    endtask

    // Driver: one call per clock; inputs change on the falling edge and the
    // expected post-edge state is queued for the monitor.
    task automatic cyc(input bit i, input bit d, input bit c, input bit r);
        exp_t e;
        bit was_up;
        @(negedge clk);
        was_up  = rst_n;
        inc_btn = i;
        dec_btn = d;
        clr     = c;
        rst_n   = r;
        if (!r) begin
            model_reset();
            if (was_up) begin
                #1;
                checks++;
                if ({L2, L1, L0} != 3'b000 || ovf_err || udf_err || !empty) begin
                    errors++;
                    $display("FAIL async_reset: got L=%b ovf=%b udf=%b empty=%b, want L=000 ovf=0 udf=0 empty=1",
                             {L2, L1, L0}, ovf_err, udf_err, empty);
                end
            end
            e.cnt = 0; e.ovf = 1'b0; e.udf = 1'b0;
        end else begin
            model_edge(i, d, c, e);
        end
        sb.push_back(e);
    endtask

    task automatic hold(input bit i, input bit d, input bit c, input int n);
        for (int k = 0; k < n; k++) cyc(i, d, c, 1'b1);
    endtask

    task automatic press_inc();
        hold(1'b1, 1'b0, 1'b0, N + 4);
        hold(1'b0, 1'b0, 1'b0, N + 4);
    endtask

    task automatic press_dec();
        hold(1'b0, 1'b1, 1'b0, N + 4);
        hold(1'b0, 1'b0, 1'b0, N + 4);
    endtask

    // Monitor: compares the DUT one step after each active edge.
    always @(posedge clk) begin
        exp_t e;
        logic [2:0] want;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            want = 3'(e.cnt);
            checks++;
            if ({L2, L1, L0} != want || full != (e.cnt == MAXL) || empty != (e.cnt == 0) ||
                ovf_err != e.ovf || udf_err != e.udf) begin
                errors++;
                $display("FAIL cycle_state @%0t: got L=%b full=%b empty=%b ovf=%b udf=%b, want L=%b full=%b empty=%b ovf=%b udf=%b",
                         $time, {L2, L1, L0}, full, empty, ovf_err, udf_err,
                         want, (e.cnt == MAXL), (e.cnt == 0), e.ovf, e.udf);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        hold(1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Held increment: one step, six edges after first sample.
        hold(1'b1, 1'b0, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 8);

        // Bounce then stable high: single step.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 1'b0, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 8);

        // Saturation and overflow.
        hold(1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 8; k++) press_inc();

        // Underflow at empty.
        hold(1'b0, 1'b0, 1'b1, 1);
        press_dec();

        // Coincident presses at count 3, then clear racing an increment at full.
        for (int k = 0; k < 3; k++) press_inc();
        hold(1'b1, 1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 8);
        for (int k = 0; k < 4; k++) press_inc();
        hold(1'b1, 1'b0, 1'b0, N + 2);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 1'b0, 1'b0, 3);
        hold(1'b0, 1'b0, 1'b0, 8);

        // Reset mid-debounce with the button held through release.
        hold(1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 5; k++) press_inc();
        hold(1'b1, 1'b0, 1'b0, 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 8);

        // Randomised bursty buttons with occasional clear and reset.
        for (int seg = 0; seg < 600; seg++) begin
            bit i, d;
            int len;
            i   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 2 * N + 3);
            for (int k = 0; k < len; k++) begin
                cyc(i, d, 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 399) != 0));
            end
        end
        hold(1'b0, 1'b0, 1'b0, 12);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_counter.md
Name: load_counter

Overview:
Upstream source of the 3-bit load code consumed by the 7-segment load decoder. Takes two raw push-buttons (increment, decrement), synchronises and debounces them, and converts each clean press into one step of a saturating 0..MAX_LOAD occupancy counter. Drives the counter bits directly to the decoder inputs and flags full/empty and rejected operations.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a button level is accepted (>=2)
MAX_LOAD, 7, saturation ceiling of the counter (1..7)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inc_btn  input  1  raw increment button, asynchronous to clk, active high
dec_btn  input  1  raw decrement button, asynchronous to clk, active high
clr  input  1  synchronous clear of the count, active high
L2  output  1  count bit 2 (MSB), to decoder input I2
L1  output  1  count bit 1, to decoder input I1
L0  output  1  count bit 0 (LSB), to decoder input I0
full  output  1  count == MAX_LOAD
empty  output  1  count == 0
ovf_err  output  1  one-cycle pulse: increment rejected at full
udf_err  output  1  one-cycle pulse: decrement rejected at empty

Behaviour:
- Reset (rst_n low, asynchronous): all flops cleared; count=0, L2..L0=000, empty=1, full=0, ovf_err=0, udf_err=0; synchroniser, debounce counters, debounced levels all 0. Release is sampled on clk.
- Per button: 2-flop synchroniser -> s. Debounce counter cnt increments each cycle s != db; clears whenever s == db. When s != db and cnt == DEBOUNCE_CYCLES-1, db toggles and cnt clears.
- Press pulse = db & ~db_q (db_q = db delayed one cycle); exactly one pulse per accepted 0->1 transition; release generates nothing.
- Latency: raw input first sampled high at edge k and held -> db high after edge k+N+1 -> count updates at edge k+N+2 (N = DEBOUNCE_CYCLES; k+6 for default).
- Glitches/bounce shorter than N consecutive synchronised cycles: no pulse, db unchanged.
- Count update priority per cycle: clr > (inc_p & dec_p) > inc_p > dec_p.
  - clr: count <= 0; no err pulse; concurrent press pulses discarded.
  - inc_p & dec_p same cycle: count unchanged, no err pulse.
  - inc_p only: count < MAX_LOAD -> count+1; else count held, ovf_err=1 next cycle.
  - dec_p only: count > 0 -> count-1; else count held, udf_err=1 next cycle.
- No wrap-around in either direction, ever.
- ovf_err/udf_err registered, high exactly one cycle.
- full/empty combinational decode of count register; L2..L0 driven straight from count register (glitch-free to decoder).
- Reset mid-debounce: progress lost. Button held through reset release is treated as a fresh press: pulse after N+2 cycles from first post-reset sample.
- Count register 3 bits; MAX_LOAD < 7 never lets count exceed MAX_LOAD.

Decomposition:
- Shared package: LOAD_W = 3, default DEBOUNCE_CYCLES and MAX_LOAD constants, debounce counter width derived as clog2(DEBOUNCE_CYCLES).
- One sub-module: btn_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated twice (inc, dec); ports clk, rst_n, raw, pulse.
- Top: counter register, priority logic, flag/error generation.

Test Plan:
- Reset then inc_btn held high 10 cycles -> count 0->1 exactly at edge k+6, one step only; L2..L0=001, empty=0.
- inc_btn bounce 1,0,1,0 (1-cycle each) then stable high -> single increment, no extra steps from bounce.
- Eight clean inc presses from 0 -> count saturates at 7 after seven, full=1; eighth press -> count stays 111, ovf_err high one cycle.
- From 0, clean dec press -> count stays 000, udf_err one cycle, empty stays 1.
- Count=3, inc and dec pressed simultaneously (pulses coincide) -> count stays 3, no err; then clr asserted together with inc pulse -> count 0, no ovf_err.
- Count=5, assert rst_n low mid-debounce of a held inc_btn -> count 0 immediately (async); after release with button still held -> count 1 at N+2 cycles.
